lcd_hd44780_responder: RTL

HD44780-compatible character-LCD responder: the display side of the 8-bit LCD parallel bus that our LCD driver masters. It samples E/RS/RW/DB in the `clk` domain and executes the instruction set. It holds a 2×16 DDRAM character buffer plus display and entry state, and returns busy flag/address and data on reads. It stands in for the panel in simulation and feeds an on-chip character renderer through a read port.

---
 rtl/lcd_hd44780_responder.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible display-side bus responder: samples the master's E/RS/RW/DB
// bus in the clk domain, executes the instruction set against a 2x16 DDRAM and
// returns status/data on reads. A registered read port feeds a character renderer.
module lcd_hd44780_responder #(
    parameter int BUSY_CYCLES  = 50,
    parameter int CLEAR_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_db_in,
    output logic [7:0] lcd_db_out,
    output logic       lcd_db_oe,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       entry_shift,
    output logic       busy_viol,
    output logic       mode_err,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char
);

    localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // Bus synchronizers; en_prev_q holds the previous synced E for edge detection
    logic       en_s1_q, en_s2_q, en_prev_q;
    logic       rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
    logic [7:0] db_s1_q, db_s2_q;

    // Architectural state
    logic [6:0]       ac_q, ac_d;
    logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic             inc_q, inc_d, shift_q, shift_d;
    logic             merr_q, merr_d, viol_q, viol_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       ddram_q [32];
    logic [7:0]       rd_char_q;

    logic       strobe, is_status, ac_visible, wr_en, clr_all;
    logic [4:0] wr_idx;

    // Address counter step with the two-line wrap points (0x27<->0x40, 0x67<->0x00)
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
        logic [6:0] r;
        if (up) begin
            if (a == 7'h27)                    r = 7'h40;
            else if (a == 7'h67 || a == 7'h7F) r = 7'h00;
            else                               r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    assign strobe     = en_prev_q & ~en_s2_q;
    assign is_status  = ~rs_s2_q & rw_s2_q;
    assign busy       = (cnt_q != '0);
    assign ac_visible = (ac_q[5:4] == 2'b00);
    assign wr_idx     = {ac_q[6], ac_q[3:0]};

    // Synchronize the asynchronous bus into clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_s1_q   <= 1'b0;
            en_s2_q   <= 1'b0;
            en_prev_q <= 1'b0;
            rs_s1_q   <= 1'b0;
            rs_s2_q   <= 1'b0;
            rw_s1_q   <= 1'b0;
            rw_s2_q   <= 1'b0;
            db_s1_q   <= 8'h00;
            db_s2_q   <= 8'h00;
        end else begin
            en_s1_q   <= lcd_en;
            en_s2_q   <= en_s1_q;
            en_prev_q <= en_s2_q;
            rs_s1_q   <= lcd_rs;
            rs_s2_q   <= rs_s1_q;
            rw_s1_q   <= lcd_rw;
            rw_s2_q   <= rw_s1_q;
            db_s1_q   <= lcd_db_in;
            db_s2_q   <= db_s1_q;
        end
    end

    // Decode a completed strobe into next state; busy gates everything but status reads
    always_comb begin
        ac_d    = ac_q;
        disp_d  = disp_q;
        cur_d   = cur_q;
        blink_d = blink_q;
        inc_d   = inc_q;
        shift_d = shift_q;
        merr_d  = merr_q;
        viol_d  = 1'b0;
        wr_en   = 1'b0;
        clr_all = 1'b0;
        cnt_d   = busy ? (cnt_q - CNT_W'(1)) : cnt_q;
        if (strobe && !is_status) begin
            if (busy) begin
                viol_d = 1'b1;
            end else if (!rs_s2_q) begin
                cnt_d = CNT_W'(BUSY_CYCLES);
                casez (db_s2_q)
                    8'b1???????: ac_d = db_s2_q[6:0];
                    8'b01??????: ;
                    8'b001?????: if (!db_s2_q[4]) merr_d = 1'b1;
                    8'b0001????: if (!db_s2_q[3]) ac_d = ac_step(ac_q, db_s2_q[2]);
                    8'b00001???: begin
                        disp_d  = db_s2_q[2];
                        cur_d   = db_s2_q[1];
                        blink_d = db_s2_q[0];
                    end
                    8'b000001??: begin
                        inc_d   = db_s2_q[1];
                        shift_d = db_s2_q[0];
                    end
                    8'b0000001?: begin
                        ac_d  = 7'h00;
                        cnt_d = CNT_W'(CLEAR_CYCLES);
                    end
                    8'b00000001: begin
                        clr_all = 1'b1;
                        ac_d    = 7'h00;
                        inc_d   = 1'b1;
                        cnt_d   = CNT_W'(CLEAR_CYCLES);
                    end
                    default: cnt_d = cnt_q;  // 0x00 no-op leaves the counter idle
                endcase
            end else begin
                // Data write lands only on visible cells; both write and read step ac
                wr_en = ~rw_s2_q & ac_visible;
                ac_d  = ac_step(ac_q, inc_q);
                cnt_d = CNT_W'(BUSY_CYCLES);
            end
        end
    end

    // Register architectural state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ac_q    <= 7'h00;
            disp_q  <= 1'b0;
            cur_q   <= 1'b0;
            blink_q <= 1'b0;
            inc_q   <= 1'b1;
            shift_q <= 1'b0;
            merr_q  <= 1'b0;
            viol_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ac_q    <= ac_d;
            disp_q  <= disp_d;
            cur_q   <= cur_d;
            blink_q <= blink_d;
            inc_q   <= inc_d;
            shift_q <= shift_d;
            merr_q  <= merr_d;
            viol_q  <= viol_d;
            cnt_q   <= cnt_d;
        end
    end

    // DDRAM held in flops so clear display can blank every cell in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) ddram_q[i] <= 8'h20;
        end else if (clr_all) begin
            for (int i = 0; i < 32; i++) ddram_q[i] <= 8'h20;
        end else if (wr_en) begin
            ddram_q[wr_idx] <= db_s2_q;
        end
    end

    // Renderer read port: registered, returns pre-write contents on a same-cycle write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_char_q <= 8'h20;
        else     rd_char_q <= ddram_q[rd_addr];
    end

    // Bus read data follows the synchronized E/RW/RS
    always_comb begin
        lcd_db_out = 8'h00;
        if (en_s2_q && rw_s2_q) begin
            if (!rs_s2_q)        lcd_db_out = {busy, ac_q};
            else if (ac_visible) lcd_db_out = ddram_q[wr_idx];
            else                 lcd_db_out = 8'h20;
        end
    end

    assign lcd_db_oe   = en_s2_q & rw_s2_q;
    assign ac          = ac_q;
    assign disp_on     = disp_q;
    assign cursor_on   = cur_q;
    assign blink_on    = blink_q;
    assign entry_inc   = inc_q;
    assign entry_shift = shift_q;
    assign busy_viol   = viol_q;
    assign mode_err    = merr_q;
    assign rd_char     = rd_char_q;

endmodule
